// File: rtl/gcd_pkg.sv
// Shared types and defaults for the binary (Stein) GCD unit.
package gcd_pkg;

    // Default operand/result width.
    localparam int unsigned GCD_WIDTH = 32;

    // Width of the iteration counter exposed when GCD_ITER_COUNT_EN is defined.
    localparam int unsigned ITER_CNT_WIDTH = 16;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    // Shift-count width: enough bits to count every factor of two a WIDTH-bit value can hold.
    function automatic int unsigned shift_width(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/gcd_step.sv
// One Stein-algorithm step: given the working operands and the common power-of-two count,
// produce the next operands and count. eq flags that the operands have converged, which
// ends the computation.
module gcd_step
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH,
    parameter int unsigned NW    = shift_width(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [NW-1:0]    n,
    output logic [WIDTH-1:0] a_next,
    output logic [WIDTH-1:0] b_next,
    output logic [NW-1:0]    n_next,
    output logic             eq
);

    // Apply the first matching reduction rule; operands are unchanged once equal.
    always_comb begin
        a_next = a;
        b_next = b;
        n_next = n;
        eq     = (a == b);
        if (eq) begin
            a_next = a;
        end else if (!a[0] && !b[0]) begin
            // Common factor of two: strip it and remember it for the final shift.
            a_next = a >> 1;
            b_next = b >> 1;
            n_next = n + 1'b1;
        end else if (!a[0]) begin
            a_next = a >> 1;
        end else if (!b[0]) begin
            b_next = b >> 1;
        end else if (a > b) begin
            // Both odd: the difference is even, so the next step halves it.
            a_next = a - b;
        end else begin
            b_next = b - a;
        end
    end

endmodule

// File: rtl/gcd.sv
// Multi-cycle binary GCD unit with a start/ready/done_tick handshake.
// Operands are captured on an accepted start; the result stays in gcd_out until the next
// operation completes. A zero operand yields 0 without entering the iteration loop.
// Optional build macro GCD_ITER_COUNT_EN adds iter_cnt, the number of OP-state cycles spent
// on the most recent operation (saturating, cleared on accepted start).
module gcd
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done_tick,
    output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [ITER_CNT_WIDTH-1:0] iter_cnt
`endif
);

    localparam int unsigned NW = shift_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [NW-1:0]    n_reg;

    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [NW-1:0]    n_next;
    logic             eq;

    logic             accept;
    logic             zero_op;

    assign accept  = (state == IDLE) && start;
    assign zero_op = (a_in == '0) || (b_in == '0);

    gcd_step #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) u_step (
        .a      (a_reg),
        .b      (b_reg),
        .n      (n_reg),
        .a_next (a_next),
        .b_next (b_next),
        .n_next (n_next),
        .eq     (eq)
    );

    // Controller and datapath registers; ready/done_tick are registered copies of the
    // next-state decode so they track IDLE/DONE exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            n_reg     <= '0;
            gcd_out   <= '0;
            done_tick <= 1'b0;
            ready     <= 1'b1;
        end else begin
            done_tick <= 1'b0;
            ready     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        n_reg <= '0;
                        if (zero_op) begin
                            gcd_out   <= '0;
                            done_tick <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= OP;
                        end
                    end else begin
                        ready <= 1'b1;
                    end
                end
                OP: begin
                    if (eq) begin
                        // Restore the common power of two; the true gcd always fits.
                        gcd_out   <= a_reg << n_reg;
                        done_tick <= 1'b1;
                        state     <= DONE;
                    end else begin
                        a_reg <= a_next;
                        b_reg <= b_next;
                        n_reg <= n_next;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef GCD_ITER_COUNT_EN
    logic [ITER_CNT_WIDTH-1:0] iter_q;

    // Count OP cycles of the current operation, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_q <= '0;
        end else if (accept) begin
            iter_q <= '0;
        end else if ((state == OP) && (iter_q != {ITER_CNT_WIDTH{1'b1}})) begin
            iter_q <= iter_q + 1'b1;
        end
    end

    assign iter_cnt = iter_q;
`endif

endmodule

// File: tb/tb_gcd.sv
// Self-checking bench for gcd: stimulus pushes expected results into a scoreboard; a
// monitor pops and compares on every done_tick.
module tb_gcd;
    import gcd_pkg::*;

    localparam int unsigned W       = 32;
    localparam int          LAT_MAX = 3 * W + 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ready;
    logic         done_tick;
    logic [W-1:0] gcd_out;
`ifdef GCD_ITER_COUNT_EN
    logic [15:0]  iter_cnt;
`endif

    gcd #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .ready     (ready),
        .done_tick (done_tick),
        .gcd_out   (gcd_out)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_cnt  (iter_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] g;
        int           issue;
        bit           exact;
        int           steps;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    bit   chk_ready = 1'b0;
    int   lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
        end
    endtask

    // Reference count of OP-state cycles (every step including the final equal step).
    function automatic int ref_steps(input logic [W-1:0] a0, input logic [W-1:0] b0);
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           s;
        a = a0;
        b = b0;
        s = 0;
        if (a == '0 || b == '0) return 0;
        while (s < 1000) begin
            s++;
            if (a == b) break;
            else if (!a[0] && !b[0]) begin a = a >> 1; b = b >> 1; end
            else if (!a[0]) a = a >> 1;
            else if (!b[0]) b = b >> 1;
            else if (a > b) a = a - b;
            else b = b - a;
        end
        return s;
    endfunction

    // Monitor: compare every done_tick against the scoreboard; the next cycle must be idle.
    always @(negedge clk) begin
        if (!reset) begin
            if (chk_ready) begin
                check("ready_after_done", {63'd0, ready}, 64'd1);
                check("done_tick_one_cycle", {63'd0, done_tick}, 64'd0);
                chk_ready = 1'b0;
            end else if (done_tick) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done_tick: got 1, expected no pending result");
                end else begin
                    e = sb.pop_front();
                    check("gcd_out", gcd_out, e.g);
                    // Cycles counted from the start-presenting cycle to the done_tick cycle.
                    lat = cyc - e.issue + 2;
                    if (e.exact) check("latency_zero_op", lat, 2);
                    else check_le("latency_bound", lat, LAT_MAX);
`ifdef GCD_ITER_COUNT_EN
                    check("iter_cnt", iter_cnt, e.steps);
`endif
                    chk_ready = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] g,
                         input bit exact);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0, expected 1");
        end
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        sb.push_back('{g: g, issue: cyc + 1, exact: exact, steps: ref_steps(a, b)});
        @(negedge clk);
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || chk_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, got %0d results missing, expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        check("reset_ready", {63'd0, ready}, 64'd1);
        check("reset_done_tick", {63'd0, done_tick}, 64'd0);
        check("reset_gcd_out", gcd_out, 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        issue(32'd6, 32'd15, 32'd3, 1'b0);
        drain("op_6_15");
        repeat (4) @(negedge clk);
        check("gcd_out_held_idle", gcd_out, 64'd3);

        issue(32'd40, 32'd60, 32'd20, 1'b0);
        drain("op_40_60");
        issue(32'd128, 32'd64, 32'd64, 1'b0);
        drain("op_128_64");
        issue(32'd588, 32'd1352, 32'd4, 1'b0);
        drain("op_588_1352");

        issue(32'd0, 32'd1, 32'd0, 1'b1);
        drain("op_0_1");
        issue(32'd1, 32'd0, 32'd0, 1'b1);
        drain("op_1_0");
        issue(32'd0, 32'd0, 32'd0, 1'b1);
        drain("op_0_0");

        // A start pulse during OP must be ignored.
        issue(32'd6, 32'd15, 32'd3, 1'b0);
        check("ready_low_in_op", {63'd0, ready}, 64'd0);
        start = 1'b1;
        a_in  = 32'd40;
        b_in  = 32'd60;
        @(negedge clk);
        start = 1'b0;
        drain("op_ignored_start");
        repeat (5) @(negedge clk);
        check("gcd_out_stable_after_ignored", gcd_out, 64'd3);

        // Reset in the middle of an operation aborts it with no done_tick.
        issue(32'd588, 32'd1352, 32'd4, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        sb.delete();
        chk_ready = 1'b0;
        #1;
        check("abort_ready", {63'd0, ready}, 64'd1);
        check("abort_gcd_out", gcd_out, 64'd0);
        check("abort_done_tick", {63'd0, done_tick}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_idle_ready", {63'd0, ready}, 64'd1);
        issue(32'd6, 32'd15, 32'd3, 1'b0);
        drain("op_after_abort");

        issue(32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 1'b0);
        drain("op_max_width");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
